// File: rtl/nios_system_clocks_pll_ctrl.sv
// System PLL sequencer: pulses the PLL reset, qualifies the synchronized lock, and
// releases the downstream system reset only after lock has been stable long enough.
module nios_system_clocks_pll_ctrl #(
    parameter int RST_PULSE_CYCLES    = 16,
    parameter int LOCK_TIMEOUT_CYCLES = 65536,
    parameter int LOCK_STABLE_CYCLES  = 1024,
    parameter int MAX_RETRIES         = 3,
    parameter int SYNC_STAGES         = 2
) (
    input  logic       refclk,
    input  logic       rst,
    input  logic       pll_locked,
    input  logic       relock_req,
    output logic       pll_rst,
    output logic       sys_rst,
    output logic       pll_fault,
    output logic [7:0] retry_count,
    output logic [7:0] lock_loss_count
);

    localparam int MAX_A   = (RST_PULSE_CYCLES > LOCK_TIMEOUT_CYCLES) ? RST_PULSE_CYCLES : LOCK_TIMEOUT_CYCLES;
    localparam int MAX_P   = (MAX_A > LOCK_STABLE_CYCLES) ? MAX_A : LOCK_STABLE_CYCLES;
    localparam int TIMER_W = $clog2(MAX_P) + 1;

    localparam logic [TIMER_W-1:0] RST_LAST     = TIMER_W'(RST_PULSE_CYCLES - 1);
    localparam logic [TIMER_W-1:0] TIMEOUT_LAST = TIMER_W'(LOCK_TIMEOUT_CYCLES - 1);
    localparam logic [TIMER_W-1:0] STABLE_LAST  = TIMER_W'(LOCK_STABLE_CYCLES - 1);
    localparam logic [7:0]         MAX_R        = 8'(MAX_RETRIES);

    typedef enum logic [2:0] {
        S_RESET_PLL = 3'd0,
        S_WAIT_LOCK = 3'd1,
        S_STABILIZE = 3'd2,
        S_RUN       = 3'd3,
        S_FAULT     = 3'd4
    } state_t;

    state_t               state;
    logic [TIMER_W-1:0]   timer;
    logic [SYNC_STAGES-1:0] sync_p;
    logic                 lock_s;

    function automatic logic [7:0] sat_inc8(input logic [7:0] v);
        return (v == 8'hFF) ? v : v + 8'd1;
    endfunction

    // Lock synchronizer: pll_locked is asynchronous to refclk.
    always_ff @(posedge refclk or posedge rst) begin
        if (rst) begin
            sync_p <= '0;
        end else begin
            sync_p <= {sync_p[SYNC_STAGES-2:0], pll_locked};
        end
    end

    assign lock_s = sync_p[SYNC_STAGES-1];

    // Sequencer: every output is a flop updated alongside the state register.
    always_ff @(posedge refclk or posedge rst) begin
        if (rst) begin
            state           <= S_RESET_PLL;
            timer           <= '0;
            pll_rst         <= 1'b1;
            sys_rst         <= 1'b1;
            pll_fault       <= 1'b0;
            retry_count     <= 8'd0;
            lock_loss_count <= 8'd0;
        end else begin
            case (state)
                S_RESET_PLL: begin
                    if (timer == RST_LAST) begin
                        state   <= S_WAIT_LOCK;
                        timer   <= '0;
                        pll_rst <= 1'b0;
                    end else begin
                        timer <= timer + 1'b1;
                    end
                end
                S_WAIT_LOCK: begin
                    if (lock_s) begin
                        state <= S_STABILIZE;
                        timer <= '0;
                    end else if (timer == TIMEOUT_LAST) begin
                        timer   <= '0;
                        pll_rst <= 1'b1;
                        if (retry_count == MAX_R) begin
                            state     <= S_FAULT;
                            pll_fault <= 1'b1;
                        end else begin
                            state       <= S_RESET_PLL;
                            retry_count <= retry_count + 8'd1;
                        end
                    end else begin
                        timer <= timer + 1'b1;
                    end
                end
                S_STABILIZE: begin
                    // Any dropout restarts the wait without consuming a retry.
                    if (!lock_s) begin
                        state <= S_WAIT_LOCK;
                        timer <= '0;
                    end else if (timer == STABLE_LAST) begin
                        state       <= S_RUN;
                        timer       <= '0;
                        sys_rst     <= 1'b0;
                        retry_count <= 8'd0;
                    end else begin
                        timer <= timer + 1'b1;
                    end
                end
                S_RUN: begin
                    timer <= '0;
                    if (!lock_s || relock_req) begin
                        state   <= S_RESET_PLL;
                        pll_rst <= 1'b1;
                        sys_rst <= 1'b1;
                        if (!lock_s) begin
                            lock_loss_count <= sat_inc8(lock_loss_count);
                        end
                    end
                end
                S_FAULT: begin
                    timer <= '0;
                    if (relock_req) begin
                        state       <= S_RESET_PLL;
                        retry_count <= 8'd0;
                        pll_fault   <= 1'b0;
                    end
                end
                default: begin
                    state     <= S_RESET_PLL;
                    timer     <= '0;
                    pll_rst   <= 1'b1;
                    sys_rst   <= 1'b1;
                    pll_fault <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: doc/nios_system_clocks_pll_ctrl.md
Name: nios_system_clocks_pll_ctrl

Overview:
Sequencer for the system PLL. It drives the PLL reset, watches the asynchronous PLL lock output, and holds the downstream system reset until lock has been stable for a qualification window. It retries a PLL reset on lock timeout, re-sequences on lock loss, and reports a fault when retries are exhausted. It sits between the board reset/reference clock and the PLL and reset-controller inputs of the clocks subsystem.

Parameters:
RST_PULSE_CYCLES, 16, number of refclk cycles pll_rst is held high per PLL reset pulse (min 1)
LOCK_TIMEOUT_CYCLES, 65536, maximum refclk cycles spent in WAIT_LOCK before a retry
LOCK_STABLE_CYCLES, 1024, consecutive cycles the synchronized lock must stay high before the system reset is released
MAX_RETRIES, 3, PLL reset retries after the initial pulse before entering FAULT (max 255)
SYNC_STAGES, 2, flops in the pll_locked synchronizer (min 2)

Ports:
refclk  in  1  reference clock (50 MHz); all logic runs on it
rst  in  1  asynchronous, active-high reset
pll_locked  in  1  PLL lock output; asynchronous to refclk
relock_req  in  1  single-cycle request to force a full re-sequence
pll_rst  out  1  PLL reset, active-high
sys_rst  out  1  downstream system reset, active-high
pll_fault  out  1  high while in FAULT
retry_count  out  8  retries consumed in the current bring-up
lock_loss_count  out  8  saturating count of lock losses seen in RUN

Behaviour:
- All outputs are dedicated flops updated on the same edge as the state register. No output is combinationally decoded.
- Values while rst is high: state=RESET_PLL, pll_rst=1, sys_rst=1, pll_fault=0, retry_count=0, lock_loss_count=0, all timers=0.
- lock_s is pll_locked passed through SYNC_STAGES flops, which are also reset by rst. lock_s lags pll_locked by SYNC_STAGES cycles.
- RESET_PLL:
  - pll_rst=1, sys_rst=1.
  - The timer counts RST_PULSE_CYCLES cycles, then the block moves to WAIT_LOCK.
  - pll_rst falls on that transition edge, so the high pulse is exactly RST_PULSE_CYCLES cycles.
- WAIT_LOCK:
  - pll_rst=0, sys_rst=1.
  - lock_s=1 -> STABILIZE, stable timer=0.
  - Timer reaches LOCK_TIMEOUT_CYCLES with lock_s=0:
    - if retry_count==MAX_RETRIES -> FAULT;
    - otherwise retry_count+1 -> RESET_PLL.
- STABILIZE:
  - lock_s=0 on any cycle -> WAIT_LOCK; the timeout timer restarts from 0 and retry_count is unchanged.
  - LOCK_STABLE_CYCLES consecutive cycles of lock_s=1 -> RUN.
  - sys_rst falls on entry to RUN. This is exactly SYNC_STAGES+LOCK_STABLE_CYCLES+1 cycles after pll_locked rises.
- RUN:
  - sys_rst=0; retry_count cleared on entry.
  - lock_s=0 -> RESET_PLL, sys_rst=1 on the same edge, lock_loss_count+1 (saturates at 255).
  - relock_req=1 -> RESET_PLL, sys_rst=1, no loss count.
  - Both events in the same cycle -> single transition, loss counted once.
- FAULT:
  - pll_rst=1, sys_rst=1, pll_fault=1.
  - Only relock_req exits: -> RESET_PLL with retry_count=0 and pll_fault=0 on the same edge.
  - lock_s is ignored in FAULT.
- relock_req is ignored in RESET_PLL, WAIT_LOCK and STABILIZE.
- Timers are sized as clog2 of the largest parameter plus 1 and never wrap; each timer is cleared on every state change.
- rst asserted mid-operation: immediate return to the reset values regardless of state. lock_loss_count is not preserved.

Test Plan:
All scenarios use RST_PULSE_CYCLES=4, LOCK_TIMEOUT_CYCLES=32, LOCK_STABLE_CYCLES=8, MAX_RETRIES=2, SYNC_STAGES=2.
1. Bring-up: release rst; pll_locked rises 10 cycles after pll_rst falls and stays high -> pll_rst high exactly 4 cycles; sys_rst falls exactly 11 cycles after pll_locked rises; retry_count=0; pll_fault=0.
2. Lock glitch: pll_locked drops for 1 cycle at the 5th STABILIZE cycle, then returns high -> sys_rst stays 1; sys_rst falls 11 cycles after the re-rise; no additional pll_rst pulse.
3. No lock: hold pll_locked=0 -> three 4-cycle pll_rst pulses, each followed by a 32-cycle wait; then pll_fault=1, pll_rst=1, retry_count=2. Pulse relock_req -> pll_fault=0, retry_count=0, new 4-cycle pulse.
4. Lock loss in RUN: drop pll_locked -> sys_rst=1 within 3 cycles; lock_loss_count goes 0->1; 4-cycle pll_rst pulse. Repeat 256 losses -> lock_loss_count holds at 255.
5. Simultaneous events in RUN: relock_req and a lock drop in the same cycle -> one re-sequence, lock_loss_count +1. relock_req alone in RUN -> re-sequence, count unchanged.
6. Asynchronous reset: assert rst mid-STABILIZE and mid-RUN without a refclk edge -> pll_rst=1, sys_rst=1 and all counters 0 immediately; after release, normal bring-up as in scenario 1.
